program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 184 ++++++++++++++++++
 tb/tb_program_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: receives a length-prefixed program image byte by byte from a
// UART receiver, writes it word by word into a downstream memory, and answers
// the sender with a single acknowledge byte (0xAA = loaded, 0x55 = rejected).
module program_loader #(
    parameter int WORD_NUM = 2048
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        mem_write_enable,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done,
    output logic        error
);

    // Word counter must be able to hold WORD_NUM itself (it ends at N).
    localparam int              CW       = $clog2(WORD_NUM + 1);
    localparam logic [CW-1:0]   WORD_ONE = CW'(1);
    localparam logic [31:0]     WORD_MAX = 32'(WORD_NUM);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HEADER  = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
    localparam logic [2:0] ST_ACK     = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;
    localparam logic [2:0] ST_ERROR   = 3'd5;

    logic [2:0]    state_r;
    logic [2:0]    state_next_s;
    logic [1:0]    byte_cnt_r;
    logic [CW-1:0] word_cnt_r;
    logic [CW-1:0] n_r;
    logic [23:0]   partial_r;
    logic          mem_we_r;
    logic [31:0]   mem_addr_r;
    logic [31:0]   mem_data_r;
    logic          tx_valid_r;
    logic [7:0]    tx_data_r;
    logic          busy_r;
    logic          done_r;
    logic          error_r;

    logic [31:0]   word_s;
    logic          rx_take_s;
    logic          last_byte_s;
    logic          last_word_s;
    logic          load_arm_s;

    // The 4th byte completes the word together with the three stored bytes.
    assign word_s      = {rx_data, partial_r};
    assign rx_take_s   = rx_valid && ((state_r == ST_HEADER) || (state_r == ST_PAYLOAD));
    assign last_byte_s = rx_take_s && (byte_cnt_r == 2'd3);
    assign last_word_s = ((word_cnt_r + WORD_ONE) == n_r);
    assign load_arm_s  = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));

    // Next-state decision for the load sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_next_s = ST_HEADER;
                else       state_next_s = ST_IDLE;
            end
            ST_HEADER: begin
                if (last_byte_s) begin
                    if (word_s == 32'd0)          state_next_s = ST_ACK;
                    else if (word_s > WORD_MAX)   state_next_s = ST_ERROR;
                    else                          state_next_s = ST_PAYLOAD;
                end else begin
                    state_next_s = ST_HEADER;
                end
            end
            ST_PAYLOAD: begin
                if (last_byte_s && last_word_s) state_next_s = ST_ACK;
                else                            state_next_s = ST_PAYLOAD;
            end
            ST_ACK: begin
                if (tx_valid_r && tx_ready) state_next_s = ST_DONE;
                else                        state_next_s = ST_ACK;
            end
            ST_DONE: begin
                if (start) state_next_s = ST_HEADER;
                else       state_next_s = ST_DONE;
            end
            ST_ERROR: begin
                state_next_s = ST_ERROR;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register and status flags registered from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            error_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == ST_HEADER) || (state_next_s == ST_PAYLOAD) ||
                       (state_next_s == ST_ACK);
            done_r  <= (state_next_s == ST_DONE);
            error_r <= (state_next_s == ST_ERROR);
        end
    end

    // Byte assembly, header length capture and word counting.
    always_ff @(posedge clock) begin
        if (reset) begin
            byte_cnt_r <= 2'd0;
            word_cnt_r <= '0;
            n_r        <= '0;
            partial_r  <= 24'd0;
        end else if (load_arm_s) begin
            byte_cnt_r <= 2'd0;
            word_cnt_r <= '0;
            n_r        <= '0;
            partial_r  <= 24'd0;
        end else if (rx_take_s) begin
            byte_cnt_r <= byte_cnt_r + 2'd1;
            case (byte_cnt_r)
                2'd0:    partial_r[7:0]   <= rx_data;
                2'd1:    partial_r[15:8]  <= rx_data;
                2'd2:    partial_r[23:16] <= rx_data;
                default: partial_r        <= partial_r;
            endcase
            if (byte_cnt_r == 2'd3) begin
                if (state_r == ST_HEADER) n_r <= word_s[CW-1:0];
                else                      word_cnt_r <= word_cnt_r + WORD_ONE;
            end
        end
    end

    // Memory write port: one-cycle strobe after each completed payload word.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_we_r   <= 1'b0;
            mem_addr_r <= 32'd0;
            mem_data_r <= 32'd0;
        end else if (last_byte_s && (state_r == ST_PAYLOAD)) begin
            mem_we_r   <= 1'b1;
            mem_addr_r <= 32'(word_cnt_r);
            mem_data_r <= word_s;
        end else begin
            mem_we_r   <= 1'b0;
        end
    end

    // Acknowledge byte: raised on entry to ACK/ERROR, dropped on handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_valid_r <= 1'b0;
            tx_data_r  <= 8'h00;
        end else if (tx_valid_r && tx_ready) begin
            tx_valid_r <= 1'b0;
        end else if ((state_r != ST_ACK) && (state_next_s == ST_ACK)) begin
            tx_valid_r <= 1'b1;
            tx_data_r  <= 8'hAA;
        end else if ((state_r != ST_ERROR) && (state_next_s == ST_ERROR)) begin
            tx_valid_r <= 1'b1;
            tx_data_r  <= 8'h55;
        end
    end

    assign mem_write_enable = mem_we_r;
    assign mem_address      = mem_addr_r;
    assign mem_write_data   = mem_data_r;
    assign tx_valid         = tx_valid_r;
    assign tx_data          = tx_data_r;
    assign busy             = busy_r;
    assign done             = done_r;
    assign error            = error_r;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed scenarios plus randomized image loads,
// compared against a byte-stream model of the load protocol.
module tb_program_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        mem_write_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        busy;
    logic        done;
    logic        error;

    int n_chk = 0;
    int n_fail = 0;
    int double_cnt = 0;
    logic we_prev = 1'b0;
    logic [31:0] pay_q[$];
    logic [63:0] wr_q[$];

    program_loader #(.WORD_NUM(2048)) dut (
        .clock(clock), .reset(reset), .start(start),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .mem_write_enable(mem_write_enable), .mem_address(mem_address),
        .mem_write_data(mem_write_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clock = ~clock;

    // Record every memory write and detect strobes longer than one cycle.
    always @(negedge clock) begin
        if (mem_write_enable) begin
            wr_q.push_back({mem_address, mem_write_data});
            if (we_prev) double_cnt++;
        end
        we_prev = mem_write_enable;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    // Idle cycles between bytes; start is toggled there since it must be ignored.
    task automatic gap(input int g);
        repeat ($urandom_range(0, g)) begin
            start = 1'($urandom_range(0, 1));
            tick();
        end
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b1; rx_valid = 1'b1; rx_data = 8'($urandom); tx_ready = 1'b1;
        tick();
        chk("rst_we", mem_write_enable, 1'b0);
        chk("rst_txv", tx_valid, 1'b0);
        chk("rst_txd", tx_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", error, 1'b0);
        reset = 1'b0; start = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
        tick();
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_we", mem_write_enable, 1'b0);
    endtask

    // One full load from IDLE or DONE: header n, payload words from pay_q,
    // acknowledge after rdy_delay cycles of tx_ready low.
    task automatic load(input logic [31:0] n, input int gaps, input int rdy_delay);
        logic [31:0] w;
        logic [7:0]  code;
        logic        is_err;
        int          exp_writes;
        is_err     = (n > 32'd2048);
        code       = is_err ? 8'h55 : 8'hAA;
        exp_writes = is_err ? 0 : int'(n);
        wr_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_hdr", busy, 1'b1);
        for (int b = 0; b < 4; b++) begin
            gap(gaps);
            w = n;
            send_byte(w[8*b +: 8]);
        end
        for (int k = 0; k < exp_writes; k++) begin
            w = pay_q[k];
            for (int b = 0; b < 4; b++) begin
                gap(gaps);
                start    = 1'($urandom_range(0, 1));
                tx_ready = 1'($urandom_range(0, 1));
                send_byte(w[8*b +: 8]);
                start = 1'b0;
                if (b < 3) chk("we_idle", mem_write_enable, 1'b0);
            end
            chk("we_strobe", mem_write_enable, 1'b1);
            chk("we_addr", mem_address, 32'(k));
            chk("we_data", mem_write_data, w);
        end
        tx_ready = 1'b0;
        chk("ack_txv", tx_valid, 1'b1);
        chk("ack_txd", tx_data, code);
        chk("ack_busy", busy, !is_err);
        chk("ack_err", error, is_err);
        repeat (rdy_delay) begin
            tick();
            chk("hold_txv", tx_valid, 1'b1);
            chk("hold_txd", tx_data, code);
            chk("hold_we", mem_write_enable, 1'b0);
            chk("hold_done", done, 1'b0);
        end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        chk("end_txv", tx_valid, 1'b0);
        chk("end_done", done, !is_err);
        chk("end_err", error, is_err);
        chk("end_busy", busy, 1'b0);
        chk("wr_count", wr_q.size(), exp_writes);
        for (int i = 0; i < wr_q.size() && i < exp_writes; i++)
            chk("wr_entry", wr_q[i], {32'(i), pay_q[i]});
    endtask

    task automatic fill_random(input int n);
        pay_q.delete();
        for (int i = 0; i < n; i++) pay_q.push_back($urandom);
    endtask

    initial begin
        logic [31:0] n;
        do_reset();

        // Bytes before start are dropped.
        wr_q.delete();
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        tick();
        chk("idle_nowr", wr_q.size(), 0);
        chk("idle_busy", busy, 1'b0);
        chk("idle_done", done, 1'b0);

        // Two-word image.
        pay_q = '{32'h11223344, 32'h55667788};
        load(32'd2, 0, 0);

        // Bytes in DONE are dropped.
        wr_q.delete();
        for (int i = 0; i < 6; i++) send_byte(8'($urandom));
        tick();
        chk("done_nowr", wr_q.size(), 0);
        chk("done_stay", done, 1'b1);
        chk("done_busy", busy, 1'b0);

        // Empty image, then a stalled acknowledge.
        load(32'd0, 0, 0);
        fill_random(1);
        load(32'd1, 0, 5);

        // Randomized reloads.
        for (int it = 0; it < 8; it++) begin
            n = 32'($urandom_range(0, 8));
            fill_random(int'(n));
            load(n, 3, $urandom_range(0, 4));
        end

        // Largest accepted image, back-to-back bytes.
        fill_random(2048);
        load(32'd2048, 0, 1);

        // Reset in the middle of a word discards it.
        do_reset();
        wr_q.delete();
        start = 1'b1; tick(); start = 1'b0;
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        do_reset();
        tick();
        chk("mid_rst_nowr", wr_q.size(), 0);
        pay_q = '{32'hAABBCCDD};
        load(32'd1, 0, 0);

        // Oversized header: error persists, later bytes and start ignored.
        load(32'd2049, 0, 2);
        wr_q.delete();
        start = 1'b1;
        for (int i = 0; i < 8; i++) send_byte(8'($urandom));
        start = 1'b0;
        tick();
        chk("err_stay", error, 1'b1);
        chk("err_txv", tx_valid, 1'b0);
        chk("err_busy", busy, 1'b0);
        chk("err_done", done, 1'b0);
        chk("err_nowr", wr_q.size(), 0);

        do_reset();
        load($urandom | 32'h0000_1000, 2, $urandom_range(0, 3));
        do_reset();
        fill_random(3);
        load(32'd3, 2, 2);

        chk("strobe_one_cycle", double_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
